prison_game_engine: RTL and testbench

Parametrised successor to the 100-prisoner/100-box interconnect: holds a loadable box memory of N_PRISONERS entries and, on `run`, plays the full prisoners' game in hardware using the cycle-following strategy, one box opened per clock. It reports overall `win`, the first failing prisoner, and total boxes opened. It sits between the host load/select/data bus and the top-level `win` result.

---
 rtl/prison_pkg.sv | 25 ++
 rtl/prison_game_engine_if.sv | 30 +++
 rtl/prison_box_bank.sv | 26 ++
 rtl/prison_game_engine.sv | 179 +++++++++++++++++
 tb/tb_prison_game_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prison_pkg.sv
// Shared types and width helpers for the prisoners' game engine.
package prison_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OPEN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_GUARD_KEY = 32'hC0FFEE00;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned ops_width(input int unsigned n, input int unsigned m);
        return $clog2(n * m + 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/prison_game_engine_if.sv
// Host load/run bus and result bus of the prisoners' game engine.
interface prison_game_engine_if
    import prison_pkg::*;
#(
    parameter int unsigned IDX_W = idx_width(100),
    parameter int unsigned OPS_W = ops_width(100, 50)
);
    logic             load_boxes;
    logic [IDX_W-1:0] select;
    logic [IDX_W-1:0] data;
    logic [31:0]      guard_key;
    logic             run;
    logic             busy;
    logic             done;
    logic             win;
    logic [IDX_W-1:0] fail_idx;
    logic [OPS_W-1:0] total_opens;
    logic             key_err;
    logic             perm_err;

    modport master (
        output load_boxes, select, data, guard_key, run,
        input  busy, done, win, fail_idx, total_opens, key_err, perm_err
    );

    modport slave (
        input  load_boxes, select, data, guard_key, run,
        output busy, done, win, fail_idx, total_opens, key_err, perm_err
    );
endinterface

// File: rtl/prison_box_bank.sv
// Box memory: one write port, one asynchronous read port, identity contents on reset.
module prison_box_bank #(
    parameter int unsigned N_PRISONERS = 100,
    parameter int unsigned IDX_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [IDX_W-1:0] rd_data_c
);
    logic [IDX_W-1:0] box_q [N_PRISONERS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_PRISONERS); i++) box_q[i] <= IDX_W'(i);
        end else if (wr_en) begin
            box_q[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last box read as zero.
    assign rd_data_c = (32'(rd_addr) < N_PRISONERS) ? box_q[rd_addr] : '0;
endmodule

// File: rtl/prison_game_engine.sv
// Plays the prisoners' game with the cycle-following strategy, one box per clock.
// Define PRISON_PERM_CHECK_EN to add a permutation pre-scan (CHECK state).
module prison_game_engine
    import prison_pkg::*;
#(
    parameter int unsigned N_PRISONERS = 100,
    parameter int unsigned MAX_OPENS   = 50,
    parameter logic [31:0] GUARD_KEY   = DEFAULT_GUARD_KEY,
    parameter int unsigned IDX_W       = idx_width(N_PRISONERS),
    parameter int unsigned OPS_W       = ops_width(N_PRISONERS, MAX_OPENS)
) (
    input logic                 clk,
    input logic                 rst,
    prison_game_engine_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(MAX_OPENS);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] p_q, p_d, cur_q, cur_d, fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OPS_W-1:0] opens_q, opens_d;
    logic             win_q, win_d;
    logic             busy_q, done_q, key_err_q;
    logic [IDX_W-1:0] rd_addr, rd_data;
    logic             in_game, load_ok, key_bad, run_ok;

    assign in_game = (state_q == CHECK) || (state_q == OPEN);
    assign load_ok = bus.load_boxes && !in_game && (bus.guard_key == GUARD_KEY)
                     && (32'(bus.select) < N_PRISONERS);
    assign key_bad = bus.load_boxes && !in_game && (bus.guard_key != GUARD_KEY);
    assign run_ok  = bus.run && ((state_q == IDLE) || (state_q == DONE)) && !load_ok;

    prison_box_bank #(.N_PRISONERS(N_PRISONERS), .IDX_W(IDX_W)) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_ok),
        .wr_addr   (bus.select),
        .wr_data   (bus.data),
        .rd_addr   (rd_addr),
        .rd_data_c (rd_data)
    );

`ifdef PRISON_PERM_CHECK_EN
    logic [N_PRISONERS-1:0] seen_q, seen_d;
    logic [IDX_W-1:0]       scan_q, scan_d;
    logic                   dup_q, dup_d, perm_q, perm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_q <= '0;
            scan_q <= '0;
            dup_q  <= 1'b0;
            perm_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
            scan_q <= scan_d;
            dup_q  <= dup_d;
            perm_q <= perm_d;
        end
    end
    assign bus.perm_err = perm_q;
`else
    assign bus.perm_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        opens_d = opens_q;
        win_d   = win_q;
        fail_d  = fail_q;
        rd_addr = cur_q;
`ifdef PRISON_PERM_CHECK_EN
        seen_d  = seen_q;
        scan_d  = scan_q;
        dup_d   = dup_q;
        perm_d  = perm_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (load_ok || run_ok) begin
                    opens_d = '0;
                    win_d   = 1'b0;
                    fail_d  = '0;
                    p_d     = '0;
                    cur_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef PRISON_PERM_CHECK_EN
                    perm_d  = 1'b0;
                    seen_d  = '0;
                    scan_d  = '0;
                    dup_d   = 1'b0;
                    if (run_ok) state_d = CHECK;
`else
                    if (run_ok) state_d = OPEN;
`endif
                end
            end
`ifdef PRISON_PERM_CHECK_EN
            // Full-length scan; a duplicate only takes effect at the end.
            CHECK: begin
                rd_addr = scan_q;
                if ((32'(rd_data) >= N_PRISONERS) || seen_q[rd_data]) dup_d = 1'b1;
                else seen_d[rd_data] = 1'b1;
                if (32'(scan_q) == N_PRISONERS - 1) begin
                    if (dup_d) begin
                        state_d = DONE;
                        perm_d  = 1'b1;
                        win_d   = 1'b0;
                        opens_d = '0;
                    end else begin
                        state_d = OPEN;
                    end
                end else begin
                    scan_d = scan_q + IDX_W'(1);
                end
            end
`endif
            OPEN: begin
                if (opens_q != '1) opens_d = opens_q + OPS_W'(1);
                if (rd_data == p_q) begin
                    if (32'(p_q) == N_PRISONERS - 1) begin
                        state_d = DONE;
                        win_d   = 1'b1;
                        fail_d  = '0;
                    end else begin
                        p_d   = p_q + IDX_W'(1);
                        cur_d = p_q + IDX_W'(1);
                        cnt_d = '0;
                    end
                end else if (32'(cnt_q) + 32'd1 == MAX_OPENS) begin
                    state_d = DONE;
                    win_d   = 1'b0;
                    fail_d  = p_q;
                end else begin
                    cur_d = rd_data;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            p_q       <= '0;
            cur_q     <= '0;
            cnt_q     <= '0;
            opens_q   <= '0;
            win_q     <= 1'b0;
            fail_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            opens_q   <= opens_d;
            win_q     <= win_d;
            fail_q    <= fail_d;
            busy_q    <= (state_d == CHECK) || (state_d == OPEN);
            done_q    <= (state_d == DONE);
            key_err_q <= key_bad;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.win         = win_q;
    assign bus.fail_idx    = fail_q;
    assign bus.total_opens = opens_q;
    assign bus.key_err     = key_err_q;
endmodule

// File: tb/tb_prison_game_engine.sv
// Bench for prison_game_engine: directed and random games against a strategy-level model.
// Expectations follow PRISON_PERM_CHECK_EN when it is defined.
module tb_prison_game_engine;
    import prison_pkg::*;

    localparam int unsigned N     = 100;
    localparam int unsigned M     = 50;
    localparam int unsigned IDX_W = idx_width(N);
    localparam int unsigned OPS_W = ops_width(N, M);
    localparam logic [31:0] GK    = DEFAULT_GUARD_KEY;
    localparam int          LIMIT = N + N * M + 20;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   mbox [N];
    int   pend [N];

    always #5 clk = ~clk;

    prison_game_engine_if #(.IDX_W(IDX_W), .OPS_W(OPS_W)) bus ();

    prison_game_engine #(.N_PRISONERS(N), .MAX_OPENS(M), .GUARD_KEY(GK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Strategy-level reference: each prisoner follows the chain from his own box.
    function automatic void model_play(output bit w, output int f, output int t,
                                       output bit pe, output int lat);
        bit seen [N];
        bit found;
        int cur;
        w = 1'b1; f = 0; t = 0; pe = 1'b0; lat = 1;
`ifdef PRISON_PERM_CHECK_EN
        lat += N;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mbox[i] >= N || seen[mbox[i]]) pe = 1'b1;
            else seen[mbox[i]] = 1'b1;
        end
        if (pe) begin
            w = 1'b0;
            return;
        end
`endif
        for (int p = 0; p < N; p++) begin
            cur = p;
            found = 1'b0;
            for (int k = 0; k < M && !found; k++) begin
                t++;
                if (mbox[cur] == p) found = 1'b1;
                else cur = mbox[cur];
            end
            if (!found) begin
                w = 1'b0;
                f = p;
                break;
            end
        end
        lat += t;
    endfunction

    task automatic drive_idle();
        bus.load_boxes = 1'b0;
        bus.select     = '0;
        bus.data       = '0;
        bus.guard_key  = GK;
        bus.run        = 1'b0;
    endtask

    task automatic load_box(input int idx, input int val, input logic [31:0] key);
        @(negedge clk);
        bus.load_boxes = 1'b1;
        bus.select     = IDX_W'(idx);
        bus.data       = IDX_W'(val);
        bus.guard_key  = key;
        if (key == GK && idx < N) mbox[idx] = val;
        @(negedge clk);
        bus.load_boxes = 1'b0;
        bus.guard_key  = GK;
    endtask

    task automatic load_pend();
        for (int i = 0; i < N; i++) if (pend[i] != mbox[i]) load_box(i, pend[i], GK);
    endtask

    task automatic play(output int lat, output bit ov);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        lat = 1;
        ov  = 1'b0;
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            if (bus.busy !== 1'b1) ov = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b0) ov = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.win} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags busy/done/win=%b want 000", {bus.busy, bus.done, bus.win});
        end
        checks++;
        if (bus.fail_idx !== '0 || bus.total_opens !== '0) begin
            errors++;
            $display("FAIL reset_counts fail_idx=%0d opens=%0d want 0 0", bus.fail_idx, bus.total_opens);
        end
        checks++;
        if ({bus.key_err, bus.perm_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_errs key/perm=%b want 00", {bus.key_err, bus.perm_err});
        end
        for (int i = 0; i < N; i++) mbox[i] = i;
        rst = 1'b1;
    endtask

    // Identity, one 100-cycle, two 50-cycles, duplicate in box 5.
    task automatic test_directed_games();
        bit w, pe, ov;
        int f, t, lat, elat;
        string tag;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N; i++) begin
                case (s)
                    0:       pend[i] = i;
                    1:       pend[i] = (i + 1) % N;
                    2:       pend[i] = (i < 50) ? (i + 1) % 50 : 50 + ((i - 49) % 50);
                    default: pend[i] = (i == 5) ? 3 : i;
                endcase
            end
            tag = (s == 0) ? "identity" : (s == 1) ? "one_cycle" : (s == 2) ? "two_cycles" : "dup_box5";
            load_pend();
            model_play(w, f, t, pe, elat);
            play(lat, ov);
            checks++;
            if (bus.done !== 1'b1 || bus.win !== w || bus.fail_idx !== IDX_W'(f)
                || bus.total_opens !== OPS_W'(t) || bus.perm_err !== pe) begin
                errors++;
                $display("FAIL %s_result done=%b win=%b fail=%0d opens=%0d perm=%b want 1 %b %0d %0d %b",
                         tag, bus.done, bus.win, bus.fail_idx, bus.total_opens, bus.perm_err, w, f, t, pe);
            end
            checks++;
            if (lat != elat || ov) begin
                errors++;
                $display("FAIL %s_timing latency=%0d busy_done_bad=%b want %0d 0", tag, lat, ov, elat);
            end
        end
    endtask

    task automatic test_key_err();
        bit w, pe, ov;
        int f, t, lat, elat;
        for (int i = 0; i < N; i++) pend[i] = i;
        load_pend();
        load_box(3, 7, 32'h0);
        checks++;
        if (bus.key_err !== 1'b1) begin
            errors++;
            $display("FAIL key_err_pulse got=%b want 1", bus.key_err);
        end
        @(negedge clk);
        checks++;
        if (bus.key_err !== 1'b0) begin
            errors++;
            $display("FAIL key_err_width got=%b want 0", bus.key_err);
        end
        load_box(N, 0, GK);
        checks++;
        if (bus.key_err !== 1'b0) begin
            errors++;
            $display("FAIL range_no_key_err got=%b want 0", bus.key_err);
        end
        model_play(w, f, t, pe, elat);
        play(lat, ov);
        checks++;
        if (bus.win !== w || bus.total_opens !== OPS_W'(t) || lat != elat) begin
            errors++;
            $display("FAIL key_err_box_kept win=%b opens=%0d latency=%0d want %b %0d %0d",
                     bus.win, bus.total_opens, lat, w, t, elat);
        end
    endtask

    task automatic test_busy_load();
        bit w, pe;
        int f, t, lat, elat;
        for (int i = 0; i < N; i++) pend[i] = (i + 1) % N;
        load_pend();
        model_play(w, f, t, pe, elat);
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        bus.load_boxes = 1'b1;
        bus.select = '0;
        bus.data = '0;
        bus.guard_key = 32'h0;
        @(negedge clk);
        bus.load_boxes = 1'b0;
        bus.guard_key = GK;
        lat = 2;
        checks++;
        if (bus.key_err !== 1'b0) begin
            errors++;
            $display("FAIL busy_load_key_err got=%b want 0", bus.key_err);
        end
        while (bus.done !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.win !== w || bus.fail_idx !== IDX_W'(f) || bus.total_opens !== OPS_W'(t) || lat != elat) begin
            errors++;
            $display("FAIL busy_load_ignored win=%b fail=%0d opens=%0d latency=%0d want %b %0d %0d %0d",
                     bus.win, bus.fail_idx, bus.total_opens, lat, w, f, t, elat);
        end
    endtask

    task automatic test_run_load_same_cycle();
        bit w, pe, ov;
        int f, t, lat, elat;
        @(negedge clk);
        bus.run = 1'b1;
        bus.load_boxes = 1'b1;
        bus.select = '0;
        bus.data = '0;
        mbox[0] = 0;
        @(negedge clk);
        bus.run = 1'b0;
        bus.load_boxes = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.win} !== 3'b000 || bus.total_opens !== '0) begin
            errors++;
            $display("FAIL load_beats_run busy/done/win=%b opens=%0d want 000 0",
                     {bus.busy, bus.done, bus.win}, bus.total_opens);
        end
        model_play(w, f, t, pe, elat);
        play(lat, ov);
        checks++;
        if (bus.win !== w || bus.fail_idx !== IDX_W'(f) || bus.total_opens !== OPS_W'(t) || lat != elat || ov) begin
            errors++;
            $display("FAIL load_beats_run_game win=%b fail=%0d opens=%0d latency=%0d want %b %0d %0d %0d",
                     bus.win, bus.fail_idx, bus.total_opens, lat, w, f, t, elat);
        end
    endtask

    // Random permutations, short-cycle permutations, and arbitrary contents.
    task automatic test_random_games();
        bit w, pe, ov;
        int f, t, lat, elat, kind, j, tmp, len, base;
        int order [N];
        for (int g = 0; g < 6; g++) begin
            kind = g % 3;
            for (int i = 0; i < N; i++) order[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = order[i];
                order[i] = order[j];
                order[j] = tmp;
            end
            if (kind == 0) begin
                for (int i = 0; i < N; i++) pend[i] = order[i];
            end else if (kind == 1) begin
                base = 0;
                while (base < N) begin
                    len = $urandom_range(M, 1);
                    if (base + len > N) len = N - base;
                    for (int i = 0; i < len; i++) pend[order[base + i]] = order[base + ((i + 1) % len)];
                    base += len;
                end
            end else begin
                for (int i = 0; i < N; i++) pend[i] = $urandom_range(N - 1, 0);
            end
            load_pend();
            model_play(w, f, t, pe, elat);
            play(lat, ov);
            checks++;
            if (bus.win !== w || bus.fail_idx !== IDX_W'(f) || bus.total_opens !== OPS_W'(t) || bus.perm_err !== pe) begin
                errors++;
                $display("FAIL random%0d_result win=%b fail=%0d opens=%0d perm=%b want %b %0d %0d %b",
                         g, bus.win, bus.fail_idx, bus.total_opens, bus.perm_err, w, f, t, pe);
            end
            checks++;
            if (lat != elat || ov) begin
                errors++;
                $display("FAIL random%0d_timing latency=%0d busy_done_bad=%b want %0d 0", g, lat, ov, elat);
            end
        end
    endtask

    task automatic test_reset_mid_game();
        bit w, pe, ov;
        int f, t, lat, elat;
        for (int i = 0; i < N; i++) pend[i] = (i + 1) % N;
        load_pend();
        @(negedge clk);
        bus.run = 1'b1;
        @(negedge clk);
        bus.run = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.win} !== 3'b000 || bus.total_opens !== '0) begin
            errors++;
            $display("FAIL mid_reset busy/done/win=%b opens=%0d want 000 0",
                     {bus.busy, bus.done, bus.win}, bus.total_opens);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) mbox[i] = i;
        model_play(w, f, t, pe, elat);
        play(lat, ov);
        checks++;
        if (bus.win !== w || bus.total_opens !== OPS_W'(t) || lat != elat || ov) begin
            errors++;
            $display("FAIL mid_reset_rerun win=%b opens=%0d latency=%0d want %b %0d %0d",
                     bus.win, bus.total_opens, lat, w, t, elat);
        end
    endtask

    initial begin
        test_reset();
        test_directed_games();
        test_key_err();
        test_busy_load();
        test_run_load_same_cycle();
        test_random_games();
        test_reset_mid_game();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
